// File: rtl/drive_pkg.sv
// Shared encodings for the line-follow drive controller: motor modes, FSM states
// and the inner-wheel duty helper.
package drive_pkg;

  localparam int DUTY_W_DEF = 10;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_FWD   = 2'd1,
    MODE_LEFT  = 2'd2,
    MODE_RIGHT = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FOLLOW  = 3'd1,
    ST_BLOCKED = 3'd2,
    ST_SEARCH  = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // Inner wheel slows by step per unit of |err|, never going below zero.
  function automatic int sat_inner(input int fast, input int step, input int abs_err);
    int red;
    red = abs_err * step;
    return (red >= fast) ? 0 : fast - red;
  endfunction

endpackage

// File: rtl/track_filter.sv
// Tracker input conditioning: 2-flop synchroniser, then a pattern is accepted only
// once the synchronised value has been seen unchanged on FILTER_LEN consecutive cycles.
module track_filter #(
  parameter int N_TRACK    = 3,
  parameter int FILTER_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_TRACK-1:0] i_track,
  output logic [N_TRACK-1:0] o_track_f
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [N_TRACK-1:0] r_sync1;
  logic [N_TRACK-1:0] r_sync2;
  logic [N_TRACK-1:0] r_cand;
  logic [N_TRACK-1:0] r_track_f;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Run length of the current synchronised sample, saturating at FILTER_LEN.
  always_comb begin
    if (r_sync2 != r_cand) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (r_cnt == CNT_W'(FILTER_LEN)) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_track_f <= '0;
    end else begin
      r_sync1 <= i_track;
      r_sync2 <= r_sync1;
      r_cand  <= r_sync2;
      r_cnt   <= w_cnt_nxt;
      if (w_cnt_nxt == CNT_W'(FILTER_LEN)) begin
        r_track_f <= r_sync2;
      end
    end
  end

  assign o_track_f = r_track_f;

endmodule

// File: rtl/line_follow_ctrl.sv
// Drive decision for the line-following car: filtered tracker steering, hysteretic
// obstacle stop and a timed line-search / halt recovery, all outputs registered.
module line_follow_ctrl
  import drive_pkg::*;
#(
  parameter int N_TRACK      = 3,
  parameter int FILTER_LEN   = 4,
  parameter int DIST_W       = 20,
  parameter int STOP_DIST    = 1500,
  parameter int CLEAR_HYST   = 200,
  parameter int LOST_TIMEOUT = 100,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int DUTY_FAST    = 1000,
  parameter int DUTY_SLOW    = 600,
  parameter int DUTY_STEP    = 400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_TRACK-1:0] track,
  input  logic [DIST_W-1:0]  distance,
  input  logic               dist_valid,
  output logic [1:0]         mode,
  output logic [DUTY_W-1:0]  left_duty,
  output logic [DUTY_W-1:0]  right_duty,
  output logic               obstacle,
  output logic               lost,
  output logic [2:0]         state
);

  localparam int TMR_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam logic [DIST_W:0]   SET_LIM = (DIST_W+1)'(STOP_DIST);
  localparam logic [DIST_W:0]   CLR_LIM = (DIST_W+1)'(STOP_DIST + CLEAR_HYST);
  localparam logic [DUTY_W-1:0] FAST_D  = DUTY_W'(DUTY_FAST);
  localparam logic [DUTY_W-1:0] SLOW_D  = DUTY_W'(DUTY_SLOW);

  logic [N_TRACK-1:0] w_track_f;
  logic               w_line;
  logic               w_tmo;
  int                 w_lo;
  int                 w_hi;
  int                 w_err;
  int                 w_abs;
  logic [DUTY_W-1:0]  w_inner;
  state_t             w_nxt;

  state_t             r_state;
  mode_t              r_mode;
  mode_t              r_last_dir;
  logic [DUTY_W-1:0]  r_left;
  logic [DUTY_W-1:0]  r_right;
  logic               r_obstacle;
  logic               r_lost;
  logic [TMR_W-1:0]   r_timer;

  track_filter #(
    .N_TRACK    (N_TRACK),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .i_track   (track),
    .o_track_f (w_track_f)
  );

  assign w_line = |w_track_f;
  assign w_tmo  = (r_timer == TMR_W'(LOST_TIMEOUT - 1));

  // Line centre error from the outermost set sensors; negative means line to the left.
  always_comb begin
    w_lo = 0;
    w_hi = 0;
    for (int i = N_TRACK - 1; i >= 0; i--) if (w_track_f[i]) w_lo = i;
    for (int i = 0; i < N_TRACK; i++) if (w_track_f[i]) w_hi = i;
    w_err   = w_lo + w_hi - (N_TRACK - 1);
    w_abs   = (w_err < 0) ? -w_err : w_err;
    w_inner = DUTY_W'(sat_inner(DUTY_FAST, DUTY_STEP, w_abs));
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_nxt = ST_FOLLOW;
      ST_FOLLOW:  if (r_obstacle) w_nxt = ST_BLOCKED;
                  else if (!w_line) w_nxt = ST_SEARCH;
      ST_BLOCKED: if (!r_obstacle) w_nxt = w_line ? ST_FOLLOW : ST_SEARCH;
      ST_SEARCH:  if (r_obstacle) w_nxt = ST_BLOCKED;
                  else if (w_line) w_nxt = ST_FOLLOW;
                  else if (w_tmo) w_nxt = ST_HALT;
      ST_HALT:    if (w_line) w_nxt = r_obstacle ? ST_BLOCKED : ST_FOLLOW;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_STOP;
      r_left     <= '0;
      r_right    <= '0;
      r_obstacle <= 1'b0;
      r_lost     <= 1'b0;
      r_timer    <= '0;
      r_last_dir <= MODE_RIGHT;
    end else begin
      // A zero distance means no echo and carries no information.
      if (dist_valid && distance != '0) begin
        if ({1'b0, distance} < SET_LIM) r_obstacle <= 1'b1;
        else if ({1'b0, distance} >= CLR_LIM) r_obstacle <= 1'b0;
      end
      if (w_line && w_err != 0) r_last_dir <= (w_err < 0) ? MODE_LEFT : MODE_RIGHT;
      r_timer <= (w_nxt == ST_SEARCH && r_state == ST_SEARCH) ? r_timer + 1'b1 : '0;
      r_state <= w_nxt;
      r_lost  <= (w_nxt == ST_SEARCH) || (w_nxt == ST_HALT);
      r_mode  <= MODE_STOP;
      r_left  <= '0;
      r_right <= '0;
      case (w_nxt)
        ST_FOLLOW: begin
          // Only reachable with no line straight out of IDLE; hold still then.
          if (w_line) begin
            if (w_err == 0) begin
              r_mode  <= MODE_FWD;
              r_left  <= FAST_D;
              r_right <= FAST_D;
            end else if (w_err < 0) begin
              r_mode  <= MODE_LEFT;
              r_left  <= w_inner;
              r_right <= FAST_D;
            end else begin
              r_mode  <= MODE_RIGHT;
              r_left  <= FAST_D;
              r_right <= w_inner;
            end
          end
        end
        ST_SEARCH: begin
          r_mode <= r_last_dir;
          if (r_last_dir == MODE_LEFT) r_right <= SLOW_D;
          else r_left <= SLOW_D;
        end
        default: ;
      endcase
    end
  end

  assign mode       = r_mode;
  assign left_duty  = r_left;
  assign right_duty = r_right;
  assign obstacle   = r_obstacle;
  assign lost       = r_lost;
  assign state      = r_state;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: a behavioural model predicts every output cycle,
// a monitor compares at each falling edge, plus directed spot checks.
module tb_line_follow_ctrl;

  localparam int N = 3, FL = 4, LT = 100;
  localparam int STOP_D = 1500, CLR_D = 1700;
  localparam int FAST = 1000, SLOW = 600, STEP = 400;
  localparam int S_IDLE = 0, S_FOLLOW = 1, S_BLOCKED = 2, S_SEARCH = 3, S_HALT = 4;
  localparam int M_STOP = 0, M_FWD = 1, M_LEFT = 2, M_RIGHT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  track;
  logic [19:0] distance;
  logic        dist_valid;
  logic [1:0]  mode;
  logic [9:0]  left_duty, right_duty;
  logic        obstacle, lost;
  logic [2:0]  state;

  typedef struct {
    int mode; int ld; int rd; int ob; int lost; int st;
  } out_t;

  int   total = 0;
  int   bad = 0;
  out_t exp_q[$];
  out_t x;
  bit   model_on = 0;

  // Reference model state
  int m_p0 = 0, m_p1 = 0, m_tf = 0, m_ob = 0, m_st = S_IDLE, m_srch = 0, m_ldir = M_RIGHT;
  int m_hist[$];

  line_follow_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .track      (track),
    .distance   (distance),
    .dist_valid (dist_valid),
    .mode       (mode),
    .left_duty  (left_duty),
    .right_duty (right_duty),
    .obstacle   (obstacle),
    .lost       (lost),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    out_t o;
    int s, ntf, nob, nst, lo, hi, e, a, inner, same;
    o.mode = M_STOP; o.ld = 0; o.rd = 0; o.ob = 0; o.lost = 0; o.st = S_IDLE;
    if (rst !== 1'b1) begin
      m_p0 = 0; m_p1 = 0; m_tf = 0; m_ob = 0; m_st = S_IDLE; m_srch = 0; m_ldir = M_RIGHT;
      m_hist.delete();
    end else begin
      s = m_p1; m_p1 = m_p0; m_p0 = int'(track);
      m_hist.push_back(s);
      if (m_hist.size() > FL) void'(m_hist.pop_front());
      ntf = m_tf;
      if (m_hist.size() == FL) begin
        same = 1;
        foreach (m_hist[i]) if (m_hist[i] != s) same = 0;
        if (same == 1) ntf = s;
      end
      nob = m_ob;
      if (dist_valid && distance != 0) begin
        if (distance < STOP_D) nob = 1;
        else if (distance >= CLR_D) nob = 0;
      end
      lo = -1; hi = -1;
      for (int i = 0; i < N; i++) if (((m_tf >> i) & 1) == 1) begin
        if (lo < 0) lo = i;
        hi = i;
      end
      e = (lo < 0) ? 0 : lo + hi - (N - 1);
      a = (e < 0) ? -e : e;
      inner = FAST - a * STEP;
      if (inner < 0) inner = 0;
      nst = m_st;
      case (m_st)
        S_IDLE:    nst = S_FOLLOW;
        S_FOLLOW:  nst = (m_ob != 0) ? S_BLOCKED : (lo < 0) ? S_SEARCH : S_FOLLOW;
        S_BLOCKED: nst = (m_ob != 0) ? S_BLOCKED : (lo < 0) ? S_SEARCH : S_FOLLOW;
        S_SEARCH:  nst = (m_ob != 0) ? S_BLOCKED : (lo >= 0) ? S_FOLLOW :
                         (m_srch == LT) ? S_HALT : S_SEARCH;
        default:   nst = (lo < 0) ? S_HALT : (m_ob != 0) ? S_BLOCKED : S_FOLLOW;
      endcase
      o.st = nst;
      o.ob = nob;
      o.lost = (nst == S_SEARCH || nst == S_HALT) ? 1 : 0;
      if (nst == S_FOLLOW && lo >= 0) begin
        if (e == 0) begin o.mode = M_FWD; o.ld = FAST; o.rd = FAST; end
        else if (e < 0) begin o.mode = M_LEFT; o.ld = inner; o.rd = FAST; end
        else begin o.mode = M_RIGHT; o.ld = FAST; o.rd = inner; end
      end else if (nst == S_SEARCH) begin
        o.mode = m_ldir;
        if (m_ldir == M_LEFT) o.rd = SLOW; else o.ld = SLOW;
      end
      m_srch = (nst == S_SEARCH) ? ((m_st == S_SEARCH) ? m_srch + 1 : 1) : 0;
      if (lo >= 0 && e != 0) m_ldir = (e < 0) ? M_LEFT : M_RIGHT;
      m_tf = ntf; m_ob = nob; m_st = nst;
    end
    exp_q.push_back(o);
    model_on = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one expected tuple per clock, checked away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (model_on) begin
          total++; bad++;
          $display("FAIL scoreboard_empty t=%0t got no expectation, required one", $time);
        end
      end else begin
        x = exp_q.pop_front();
        total++;
        if ({mode, left_duty, right_duty, obstacle, lost, state} !==
            {2'(x.mode), 10'(x.ld), 10'(x.rd), 1'(x.ob), 1'(x.lost), 3'(x.st)}) begin
          bad++;
          $display("FAIL cycle_out t=%0t got mode=%0d l=%0d r=%0d ob=%0d lost=%0d st=%0d required mode=%0d l=%0d r=%0d ob=%0d lost=%0d st=%0d",
                   $time, mode, left_duty, right_duty, obstacle, lost, state,
                   x.mode, x.ld, x.rd, x.ob, x.lost, x.st);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe(input int d);
    distance = 20'(d);
    dist_valid = 1'b1;
    cyc(1);
    dist_valid = 1'b0;
  endtask

  task automatic spot(input string nm, input int m, input int l, input int r,
                      input int ob, input int ls, input int st);
    total++;
    if ({mode, left_duty, right_duty, obstacle, lost, state} !==
        {2'(m), 10'(l), 10'(r), 1'(ob), 1'(ls), 3'(st)}) begin
      bad++;
      $display("FAIL %s got mode=%0d l=%0d r=%0d ob=%0d lost=%0d st=%0d required mode=%0d l=%0d r=%0d ob=%0d lost=%0d st=%0d",
               nm, mode, left_duty, right_duty, obstacle, lost, state, m, l, r, ob, ls, st);
    end
  endtask

  int hold, sel;

  initial begin
    rst = 1'b0; track = 3'b010; distance = '0; dist_valid = 1'b0;
    cyc(3);
    spot("reset", M_STOP, 0, 0, 0, 0, S_IDLE);
    rst = 1'b1;
    cyc(10);
    spot("start_fwd", M_FWD, FAST, FAST, 0, 0, S_FOLLOW);

    track = 3'b001; cyc(10);
    spot("hard_left", M_LEFT, 200, FAST, 0, 0, S_FOLLOW);
    track = 3'b011; cyc(10);
    spot("soft_left", M_LEFT, 600, FAST, 0, 0, S_FOLLOW);
    track = 3'b100; cyc(2);
    track = 3'b011; cyc(10);
    spot("glitch_ignored", M_LEFT, 600, FAST, 0, 0, S_FOLLOW);

    strobe(1400); cyc(2);
    spot("obst_set", M_STOP, 0, 0, 1, 0, S_BLOCKED);
    strobe(1600); cyc(2);
    spot("obst_hold", M_STOP, 0, 0, 1, 0, S_BLOCKED);
    strobe(0); cyc(2);
    spot("no_echo_blocked", M_STOP, 0, 0, 1, 0, S_BLOCKED);
    strobe(1700); cyc(2);
    spot("obst_clear", M_LEFT, 600, FAST, 0, 0, S_FOLLOW);
    strobe(0); cyc(2);
    spot("no_echo_clear", M_LEFT, 600, FAST, 0, 0, S_FOLLOW);

    track = 3'b110; cyc(10);
    spot("soft_right", M_RIGHT, FAST, 600, 0, 0, S_FOLLOW);
    track = 3'b000; cyc(10);
    spot("search_right", M_RIGHT, SLOW, 0, 0, 1, S_SEARCH);
    cyc(100);
    spot("halt", M_STOP, 0, 0, 0, 1, S_HALT);
    track = 3'b010; cyc(10);
    spot("halt_recover", M_FWD, FAST, FAST, 0, 0, S_FOLLOW);

    track = 3'b001; cyc(10);
    track = 3'b000; cyc(10);
    spot("search_left", M_LEFT, 0, SLOW, 0, 1, S_SEARCH);
    track = 3'b010; cyc(5);
    strobe(1000); cyc(2);
    spot("search_obst_wins", M_STOP, 0, 0, 1, 0, S_BLOCKED);
    strobe(2000); cyc(2);
    spot("blocked_to_follow", M_FWD, FAST, FAST, 0, 0, S_FOLLOW);

    track = 3'b000; cyc(10);
    strobe(1000);
    rst = 1'b0; cyc(1);
    spot("mid_reset", M_STOP, 0, 0, 0, 0, S_IDLE);
    rst = 1'b1; cyc(2);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      track = (sel < 2) ? 3'b000 : 3'($urandom_range(1, 7));
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 12);
      for (int j = 0; j < hold; j++) begin
        dist_valid = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
          0:       distance = '0;
          1:       distance = 20'($urandom_range(1300, 1900));
          2:       distance = 20'($urandom_range(1, 2999));
          default: distance = 20'($urandom);
        endcase
        rst = ($urandom_range(0, 399) != 0);
        cyc(1);
      end
    end
    dist_valid = 1'b0; rst = 1'b1;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
Parametrised drive-decision block for the line-following car. It takes N tracker channels (already inverted so 1 = line seen) and the ultrasonic distance, and produces the motor mode code plus per-wheel PWM duty. It replaces the fixed 3-channel stop/forward/turn decision with debounced inputs, proportional differential steering, obstacle hysteresis and a timed line-search/halt recovery. It sits between sonic_top/tracker inputs and the motor block.

Parameters:
N_TRACK, 3, tracker channel count; odd, >=3; bit 0 = leftmost
FILTER_LEN, 4, cycles a raw tracker pattern must hold before it is accepted
DIST_W, 20, distance width
STOP_DIST, 1500, obstacle asserts when distance < STOP_DIST
CLEAR_HYST, 200, obstacle clears when distance >= STOP_DIST+CLEAR_HYST
LOST_TIMEOUT, 100, cycles in SEARCH before HALT
DUTY_W, 10, duty width
DUTY_FAST, 1000, straight-line duty
DUTY_SLOW, 600, search spin duty
DUTY_STEP, 400, inner-wheel reduction per unit of |err|

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
track  in  N_TRACK  tracker bits, 1 = line under sensor, asynchronous to clk
distance  in  DIST_W  latest sonic distance
dist_valid  in  1  one-cycle strobe: distance is new
mode  out  2  0 STOP, 1 FORWARD, 2 LEFT, 3 RIGHT
left_duty  out  DUTY_W  left wheel duty
right_duty  out  DUTY_W  right wheel duty
obstacle  out  1  hysteretic obstacle flag
lost  out  1  high in SEARCH or HALT
state  out  3  FSM state, for debug/7-seg

Behaviour:
- Reset: clk edge with rst=0 -> state IDLE, mode STOP, both duties 0, obstacle 0, lost 0, filter and timers cleared. Same result mid-operation.
- Input path: 2-FF synchroniser on track. track_f loads the synchronised value only after it has held unchanged for FILTER_LEN consecutive cycles. Reset value of track_f is 0.
- Error: lo/hi = lowest/highest set index of track_f. err = lo + hi - (N_TRACK-1), signed, range +/-(N_TRACK-1). err<0 means the line is to the left.
- Steer in FOLLOW:
  - err==0: FORWARD, both duties DUTY_FAST. All bits set also gives err==0.
  - err<0: LEFT, right=DUTY_FAST, left=DUTY_FAST-|err|*DUTY_STEP, saturating at 0.
  - err>0: RIGHT, mirrored.
  - last_dir register records LEFT/RIGHT on every nonzero err.
- Obstacle:
  - Updates only on dist_valid. distance==0 (no echo) is ignored.
  - Set when distance < STOP_DIST. Cleared when distance >= STOP_DIST+CLEAR_HYST. Values in between hold.
  - Comparison widened by 1 bit so there is no overflow.
- FSM (priority: obstacle > line lost > follow):
  - IDLE -> FOLLOW on the first cycle after reset release.
  - FOLLOW -> BLOCKED if obstacle. -> SEARCH if track_f==0 (timer cleared).
  - BLOCKED: mode STOP, duties 0. -> FOLLOW when obstacle clears and track_f!=0. -> SEARCH when obstacle clears and track_f==0.
  - SEARCH: spin toward last_dir (mode=last_dir; outer wheel DUTY_SLOW, inner 0). Timer counts each cycle. -> FOLLOW when track_f!=0. -> HALT when timer == LOST_TIMEOUT-1. -> BLOCKED if obstacle.
  - HALT: STOP, duties 0, lost=1. -> FOLLOW when track_f!=0. Obstacle still tracked.
  - Simultaneous obstacle-set and line-found in SEARCH -> BLOCKED.
- Timing: all outputs registered. Outputs reflect the FSM decision one cycle after the track_f/obstacle change. Total track-to-output latency is 2 + FILTER_LEN + 1 cycles.
- last_dir reset value is RIGHT.

Decomposition:
- Package drive_pkg: mode encodings (MODE_STOP/FWD/LEFT/RIGHT), FSM state enum (IDLE, FOLLOW, BLOCKED, SEARCH, HALT), duty width constant.
- Sub-module track_filter: synchroniser + FILTER_LEN stability counter, parametrised on N_TRACK. Instantiated once.

Test Plan:
- Defaults, rst low 3 cycles then high, track=3'b010, no dist_valid -> after 7 cycles FORWARD, duties 1000/1000, state FOLLOW.
- track=3'b001 held -> LEFT, left=200, right=1000. track=3'b011 -> LEFT, left=600. A 2-cycle glitch to 3'b100 -> no output change.
- distance=1400 with dist_valid -> next cycle obstacle=1, STOP, duties 0. Then 1600 -> stays blocked. Then 1700 -> FOLLOW resumes. distance=0 strobe -> obstacle unchanged.
- From RIGHT steering, track=0 -> SEARCH, mode RIGHT, left=600, right=0, lost=1. After 100 cycles -> HALT, STOP. Then track=3'b010 -> FOLLOW.
- In SEARCH, the same cycle obstacle sets and line reappears -> BLOCKED.
- rst low for one cycle while in SEARCH with obstacle=1 -> IDLE, STOP, duties 0, obstacle 0, lost 0.
